// File: rtl/maze_pkg.sv
// Shared maze definitions: wall-mask width, the "no wall hit" code, the
// collision FSM state type and the lowest-set-index encoder used to report
// the first wall touched in a frame.
package maze_pkg;

  localparam int NUM_WALLS = 18;

  localparam logic [4:0] NO_HIT = 5'd31;

  typedef enum logic {
    ARMED = 1'b0,
    GRACE = 1'b1
  } coll_state_t;

  // Lowest set index of a wall mask; NO_HIT when the mask is empty.
  // Scanning from the top down lets the lowest set bit win last.
  function automatic logic [4:0] lowest_set(input logic [NUM_WALLS-1:0] mask);
    logic [4:0] idx;
    idx = NO_HIT;
    for (int i = NUM_WALLS - 1; i >= 0; i--) begin
      if (mask[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame tick into the pixel clock domain and turns
// each rising edge into a single registered one-cycle frame_end pulse.
// Latency from an update rising edge to frame_end is three clk cycles
// (two synchronizer stages plus the registered edge detector).
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic update,
  output logic frame_end
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic frame_end_q, frame_end_d;

  // Next values: shift through the synchronizer, remember the last level,
  // and flag a low-to-high transition of the synchronized level.
  always_comb begin
    sync1_d     = update;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    frame_end_d = sync2_q & ~prev_q;
  end

  // Synchronizer, edge-detect history and pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign frame_end = frame_end_q;

endmodule

// File: rtl/wall_collision_detector.sv
// Intersects the per-pixel wall mask with the player box, accumulates the
// touched walls over a frame, and at each frame boundary publishes the
// frame's hit mask. A hit while ARMED pulses collision/respawn and starts a
// grace period of GRACE_FRAMES frame boundaries during which hits are still
// published but no pulses are produced.
module wall_collision_detector #(
  parameter int         NUM_WALLS    = 18,
  parameter logic [9:0] PLAYER_SIZE  = 10'd16,
  parameter logic [5:0] GRACE_FRAMES = 6'd30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update,
  input  logic [9:0]           xCount,
  input  logic [9:0]           yCount,
  input  logic [NUM_WALLS-1:0] wall,
  input  logic [9:0]           playerX,
  input  logic [9:0]           playerY,
  output logic [NUM_WALLS-1:0] hit_mask,
  output logic [4:0]           first_hit,
  output logic                 collision,
  output logic                 respawn,
  output logic [7:0]           collision_count,
  output logic                 in_grace
);

  import maze_pkg::*;

  // ---------------------------------------------------------------------
  // Frame boundary
  // ---------------------------------------------------------------------
  logic frame_end;

  frame_tick_sync u_tick (
    .clk       (clk),
    .rst       (rst),
    .update    (update),
    .frame_end (frame_end)
  );

  // ---------------------------------------------------------------------
  // Player box and overlap
  // ---------------------------------------------------------------------
  // Box far edges wrap modulo 1024 on purpose; no saturation.
  logic [9:0] x_end;
  logic [9:0] y_end;
  logic       player_px;

  assign x_end = playerX + PLAYER_SIZE;
  assign y_end = playerY + PLAYER_SIZE;

  assign player_px = (xCount > playerX) && (xCount < x_end) &&
                     (yCount > playerY) && (yCount < y_end);

  logic                 player_q, player_d;
  logic [NUM_WALLS-1:0] acc_q, acc_d;
  logic [NUM_WALLS-1:0] ovl;
  logic [NUM_WALLS-1:0] pub;
  logic                 pub_any;

  // player_q lines up with wall, which arrives one clk after its pixel.
  assign ovl     = wall & {NUM_WALLS{player_q}};
  // The overlap seen in the frame_end cycle belongs to the closing frame.
  assign pub     = acc_q | ovl;
  assign pub_any = |pub;

  // Accumulate overlaps; clear at the boundary without carrying the
  // boundary-cycle overlap forward (it was published instead).
  always_comb begin
    player_d = player_px;
    acc_d    = acc_q | ovl;
    if (frame_end) acc_d = '0;
  end

  // Pixel-alignment register and hit accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      player_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      player_q <= player_d;
      acc_q    <= acc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Collision FSM
  // ---------------------------------------------------------------------
  coll_state_t state_q, state_d;

  logic [5:0] grace_cnt_q, grace_cnt_d;
  logic [NUM_WALLS-1:0] hit_mask_q, hit_mask_d;
  logic [4:0] first_hit_q, first_hit_d;
  logic       collision_q, collision_d;
  logic       respawn_q, respawn_d;
  logic [7:0] count_q, count_d;
  logic       fire;

  // A publish with hits while ARMED is what produces the pulses.
  assign fire = frame_end && (state_q == ARMED) && pub_any;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARMED;
    else     state_q <= state_d;
  end

  // Next state: enter GRACE on a fired collision (unless grace is disabled),
  // leave GRACE on the boundary where the countdown has already reached 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARMED: if (fire && (GRACE_FRAMES != 6'd0)) state_d = GRACE;
      GRACE: if (frame_end && (grace_cnt_q == 6'd0)) state_d = ARMED;
      default: state_d = ARMED;
    endcase
  end

  // Outputs and counters: publish on every boundary, pulse on fire, manage
  // the grace countdown and the saturating collision counter.
  always_comb begin
    hit_mask_d  = hit_mask_q;
    first_hit_d = first_hit_q;
    collision_d = 1'b0;
    respawn_d   = 1'b0;
    count_d     = count_q;
    grace_cnt_d = grace_cnt_q;
    if (frame_end) begin
      hit_mask_d  = pub;
      first_hit_d = lowest_set(pub);
    end
    if (fire) begin
      collision_d = 1'b1;
      respawn_d   = 1'b1;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
      if (GRACE_FRAMES != 6'd0) grace_cnt_d = GRACE_FRAMES - 6'd1;
    end
    if (frame_end && (state_q == GRACE) && (grace_cnt_q != 6'd0)) begin
      grace_cnt_d = grace_cnt_q - 6'd1;
    end
  end

  // Registered outputs and grace counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_mask_q  <= '0;
      first_hit_q <= NO_HIT;
      collision_q <= 1'b0;
      respawn_q   <= 1'b0;
      count_q     <= 8'd0;
      grace_cnt_q <= 6'd0;
    end else begin
      hit_mask_q  <= hit_mask_d;
      first_hit_q <= first_hit_d;
      collision_q <= collision_d;
      respawn_q   <= respawn_d;
      count_q     <= count_d;
      grace_cnt_q <= grace_cnt_d;
    end
  end

  assign hit_mask        = hit_mask_q;
  assign first_hit       = first_hit_q;
  assign collision       = collision_q;
  assign respawn         = respawn_q;
  assign collision_count = count_q;
  assign in_grace        = (state_q == GRACE);

endmodule

// File: tb/tb_wall_collision_detector.sv
// Directed bench for wall_collision_detector. Three instances share all
// inputs and differ only in GRACE_FRAMES (30, 2, 0). Each frame's expected
// publish is derived from the driven pixels; a per-instance grace model
// produces expected outputs, which are queued and compared on publish.
module tb_wall_collision_detector;

  localparam int W  = 18;
  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       update;
  logic [9:0] xCount, yCount, playerX, playerY;
  logic [W-1:0] wall, wall_next;

  logic [W-1:0] hm  [NI];
  logic [4:0]   fh  [NI];
  logic         col [NI];
  logic         rsp [NI];
  logic [7:0]   cnt [NI];
  logic         ing [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected record: {inst[1:0], hit_mask[17:0], first_hit[4:0], coll, count[7:0], in_grace}
  logic [34:0] exp_q[$];

  // Pixel list for the current frame.
  int           px_x[$];
  int           px_y[$];
  logic [W-1:0] px_w[$];

  // Per-instance model of the collision controller.
  int   grace_cfg [NI] = '{30, 2, 0};
  logic armed     [NI];
  int   gcnt      [NI];
  int   ccount    [NI];

  always #5 clk = ~clk;

  // Upstream wall generators register the mask one clk after the pixel.
  always @(posedge clk) wall <= wall_next;

  wall_collision_detector #(.GRACE_FRAMES(6'd30)) u0 (
    .clk(clk), .rst(rst), .update(update), .xCount(xCount), .yCount(yCount),
    .wall(wall), .playerX(playerX), .playerY(playerY),
    .hit_mask(hm[0]), .first_hit(fh[0]), .collision(col[0]), .respawn(rsp[0]),
    .collision_count(cnt[0]), .in_grace(ing[0]));

  wall_collision_detector #(.GRACE_FRAMES(6'd2)) u1 (
    .clk(clk), .rst(rst), .update(update), .xCount(xCount), .yCount(yCount),
    .wall(wall), .playerX(playerX), .playerY(playerY),
    .hit_mask(hm[1]), .first_hit(fh[1]), .collision(col[1]), .respawn(rsp[1]),
    .collision_count(cnt[1]), .in_grace(ing[1]));

  wall_collision_detector #(.GRACE_FRAMES(6'd0)) u2 (
    .clk(clk), .rst(rst), .update(update), .xCount(xCount), .yCount(yCount),
    .wall(wall), .playerX(playerX), .playerY(playerY),
    .hit_mask(hm[2]), .first_hit(fh[2]), .collision(col[2]), .respawn(rsp[2]),
    .collision_count(cnt[2]), .in_grace(ing[2]));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, inst, obs, expv);
    end
  endtask

  function automatic logic in_box(input int x, input int y);
    logic [9:0] xx, yy, xe, ye;
    xx = 10'(x);
    yy = 10'(y);
    xe = playerX + 10'd16;
    ye = playerY + 10'd16;
    return (xx > playerX) && (xx < xe) && (yy > playerY) && (yy < ye);
  endfunction

  function automatic logic [4:0] low_idx(input logic [W-1:0] m);
    for (int i = 0; i < W; i++) if (m[i]) return 5'(i);
    return 5'd31;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      armed[i]  = 1'b1;
      gcnt[i]   = 0;
      ccount[i] = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_hit_mask"}, i, 32'(hm[i]), 32'd0);
      chk({tag, "_first_hit"}, i, 32'(fh[i]), 32'd31);
      chk({tag, "_collision"}, i, 32'(col[i]), 32'd0);
      chk({tag, "_respawn"}, i, 32'(rsp[i]), 32'd0);
      chk({tag, "_count"}, i, 32'(cnt[i]), 32'd0);
      chk({tag, "_in_grace"}, i, 32'(ing[i]), 32'd0);
    end
  endtask

  task automatic add_px(input int x, input int y, input logic [W-1:0] w);
    px_x.push_back(x);
    px_y.push_back(y);
    px_w.push_back(w);
  endtask

  task automatic idle_px();
    xCount    = 10'd0;
    yCount    = 10'd0;
    wall_next = '0;
  endtask

  // Runs one frame: drives the queued pixels, optionally one pixel whose
  // overlap lands exactly in the frame_end cycle, then the update edge.
  task automatic run_frame(input logic late, input int lx, input int ly,
                           input logic [W-1:0] lw);
    logic [W-1:0] pub;
    logic         coll;
    logic [34:0]  e;
    pub = '0;
    while (px_x.size() > 0) begin
      int x, y;
      logic [W-1:0] w;
      x = px_x.pop_front();
      y = px_y.pop_front();
      w = px_w.pop_front();
      if (in_box(x, y)) pub |= w;
      @(negedge clk);
      xCount = 10'(x);
      yCount = 10'(y);
      wall_next = w;
    end
    if (late && in_box(lx, ly)) pub |= lw;
    // Expected results for every instance, pushed when stimulus is driven.
    for (int i = 0; i < NI; i++) begin
      coll = 1'b0;
      if (armed[i]) begin
        if (pub != '0) begin
          coll = 1'b1;
          if (ccount[i] < 255) ccount[i]++;
          if (grace_cfg[i] != 0) begin
            gcnt[i]  = grace_cfg[i] - 1;
            armed[i] = 1'b0;
          end
        end
      end else begin
        if (gcnt[i] == 0) armed[i] = 1'b1;
        else gcnt[i]--;
      end
      e = {2'(i), pub, low_idx(pub), coll, 8'(ccount[i]), ~armed[i]};
      exp_q.push_back(e);
    end
    @(negedge clk);
    idle_px();
    update = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (late) begin
      xCount    = 10'(lx);
      yCount    = 10'(ly);
      wall_next = lw;
    end
    @(negedge clk);
    idle_px();
    for (int i = 0; i < NI; i++) chk("pre_publish_collision", i, 32'(col[i]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", i, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("inst_order", i, 32'(e[34:33]), 32'(i));
        chk("hit_mask", i, 32'(hm[i]), 32'(e[32:15]));
        chk("first_hit", i, 32'(fh[i]), 32'(e[14:10]));
        chk("collision", i, 32'(col[i]), 32'(e[9]));
        chk("respawn", i, 32'(rsp[i]), 32'(e[9]));
        chk("collision_count", i, 32'(cnt[i]), 32'(e[8:1]));
        chk("in_grace", i, 32'(ing[i]), 32'(e[0]));
      end
    end
    // update still high: no second frame_end, pulse lasts one cycle.
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("pulse_width_collision", i, 32'(col[i]), 32'd0);
      chk("pulse_width_respawn", i, 32'(rsp[i]), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk("held_update_count", i, 32'(cnt[i]), 32'(ccount[i]));
    update = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_plain();
    run_frame(1'b0, 0, 0, '0);
  endtask

  task automatic queue_wall4_hit();
    add_px(100, 108, W'(1) << 5);   // left edge, not strictly inside
    for (int x = 105; x <= 110; x++) add_px(x, 108, W'(1) << 4);
    add_px(116, 108, W'(1) << 6);   // right edge, excluded
    add_px(108, 116, W'(1) << 7);   // bottom edge, excluded
  endtask

  initial begin
    rst = 1'b1;
    update = 1'b0;
    playerX = 10'd100;
    playerY = 10'd100;
    wall_next = '0;
    idle_px();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single hit on wall 4, then same hit for three more frames.
    queue_wall4_hit();
    frame_plain();
    for (int i = 0; i < 2; i++) chk("first_frame_grace", i, 32'(ing[i]), 32'd1);
    for (int f = 0; f < 3; f++) begin
      queue_wall4_hit();
      frame_plain();
    end
    chk("grace2_count", 1, 32'(cnt[1]), 32'd2);
    chk("grace30_count", 0, 32'(cnt[0]), 32'd1);

    // Reset in the middle of a frame with a pending overlap.
    @(negedge clk);
    xCount = 10'd105; yCount = 10'd108; wall_next = W'(1) << 4;
    @(negedge clk);
    idle_px();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("mid_frame_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    frame_plain();

    // Walls 3 and 17 in one frame.
    add_px(101, 101, W'(1) << 3);
    add_px(115, 115, W'(1) << 17);
    frame_plain();

    // Overlap only in the frame_end cycle, then an empty frame.
    run_frame(1'b1, 107, 107, W'(1) << 9);
    frame_plain();

    // Box far edge wraps past 1023: no pixel can satisfy the test.
    playerX = 10'd1015;
    add_px(1020, 108, W'(1) << 2);
    add_px(3, 108, W'(1) << 2);
    frame_plain();
    playerX = 10'd100;

    // 300 consecutive colliding frames.
    for (int f = 0; f < 300; f++) begin
      add_px(105, 108, W'(1) << (f % W));
      frame_plain();
    end
    chk("saturated_count", 2, 32'(cnt[2]), 32'd255);
    chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
